// File: rtl/benes_cfg_sequencer.sv
// benes_cfg_sequencer: shadow/active Benes switch configuration with drain-before-swap and valid pipeline
// Optional feature: define BENES_SEQ_PERM_CNT_EN to add the 32-bit perm_cnt output counter.
module benes_cfg_sequencer #(
   parameter int SIZE       = 32,
   parameter int SWITCH_NUM = SIZE / 2,
   parameter int STAGE_NUM  = 9,
   parameter int LATENCY    = STAGE_NUM - 1,
   parameter int STG_W      = $clog2(STAGE_NUM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_wr_en,
   input  logic [STG_W-1:0]      cfg_stage,
   input  logic [SWITCH_NUM-1:0] cfg_data,
   input  logic                  cfg_commit,
   output logic                  cfg_busy,
   output logic                  cfg_err,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  out_valid,
`ifdef BENES_SEQ_PERM_CNT_EN
   output logic [31:0]           perm_cnt,
`endif
   output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
   output logic                  cfg_loaded
);
   typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
   state_t                r_state, w_next;
   logic [SWITCH_NUM-1:0] r_shadow [0:STAGE_NUM-1];
   logic [SWITCH_NUM-1:0] r_active [0:STAGE_NUM-1];
   logic [LATENCY-1:0]    r_vsr;
   logic                  r_loaded, r_err;
   logic                  w_run, w_fire, w_wr_ok;

   assign w_run      = r_state == RUN;
   assign in_ready   = w_run & r_loaded;
   assign cfg_busy   = ~w_run;
   assign w_fire     = in_valid & in_ready;
   assign w_wr_ok    = w_run & cfg_wr_en & (int'(cfg_stage) < STAGE_NUM);
   assign out_valid  = r_vsr[LATENCY-1];
   assign switch_set = r_active;
   assign cfg_loaded = r_loaded;
   assign cfg_err    = r_err;

   // Commit leaves RUN, DRAIN waits for an empty valid pipe, SWAP lasts one cycle
   always_comb begin
      w_next = RUN;
      w_next = (r_state == RUN)   ? (cfg_commit ? DRAIN : RUN) :
               (r_state == DRAIN) ? ((r_vsr == '0) ? SWAP : DRAIN) : RUN;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_next;
   end

   // Valid pipeline tracking accepted vectors through the network
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vsr <= '0;
      else        r_vsr <= (r_vsr << 1) | LATENCY'(w_fire);
   end

   // Shadow writes, shadow-to-active transfer, loaded and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGE_NUM; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
         r_loaded <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_wr_ok) r_shadow[cfg_stage] <= cfg_data;
         if (r_state == SWAP) begin
            r_active <= r_shadow;
            r_loaded <= 1'b1;
         end
         r_err <= r_err | (cfg_wr_en & ~w_wr_ok);
      end
   end

`ifdef BENES_SEQ_PERM_CNT_EN
   logic [31:0] r_perm;
   assign perm_cnt = r_perm;

   // Count vectors leaving the network; survives commits, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_perm <= '0;
      else        r_perm <= r_perm + 32'(out_valid);
   end
`endif
endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// tb_benes_cfg_sequencer: randomized bench for benes_cfg_sequencer against a cycle-count reference model
module tb_benes_cfg_sequencer;
   localparam int ST  = 9;
   localparam int LAT = 8;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        cfg_wr_en = 1'b0, cfg_commit = 1'b0, in_valid = 1'b0;
   logic [3:0]  cfg_stage = '0;
   logic [15:0] cfg_data = '0;
   logic        cfg_busy, cfg_err, in_ready, out_valid, cfg_loaded;
   logic [15:0] switch_set [0:ST-1];
`ifdef BENES_SEQ_PERM_CNT_EN
   logic [31:0] perm_cnt;
`endif

   int checks = 0, errors = 0;

   logic [15:0] m_shadow [0:ST-1];
   logic [15:0] m_active [0:ST-1];
   bit          m_loaded, m_err, m_pend;
   int          cyc = 0, m_swap, m_last_fire;
   int          fire_q[$];
   logic [31:0] m_cnt;

   benes_cfg_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_en(cfg_wr_en), .cfg_stage(cfg_stage), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
`ifdef BENES_SEQ_PERM_CNT_EN
      .perm_cnt(perm_cnt),
`endif
      .switch_set(switch_set), .cfg_loaded(cfg_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < ST; k++) begin
         m_shadow[k] = '0;
         m_active[k] = '0;
      end
      m_loaded = 0;
      m_err = 0;
      m_pend = 0;
      m_swap = 0;
      m_last_fire = -1000;
      m_cnt = '0;
      fire_q.delete();
   endtask

   // One clock cycle: check outputs at negedge, then advance the model by the cycle's inputs
   task automatic step();
      bit busy, rdy, ov;
      @(negedge clk);
      busy = m_pend;
      rdy  = m_loaded && !busy;
      ov   = fire_q.size() > 0 && fire_q[0] == cyc - LAT;
      check("in_ready", in_ready, rdy);
      check("cfg_busy", cfg_busy, busy);
      check("out_valid", out_valid, ov);
      check("cfg_loaded", cfg_loaded, m_loaded);
      check("cfg_err", cfg_err, m_err);
      for (int k = 0; k < ST; k++) check($sformatf("switch_set[%0d]", k), switch_set[k], m_active[k]);
`ifdef BENES_SEQ_PERM_CNT_EN
      check("perm_cnt", perm_cnt, m_cnt);
`endif
      if (ov) begin
         void'(fire_q.pop_front());
         m_cnt++;
      end
      if (in_valid && rdy) begin
         fire_q.push_back(cyc);
         m_last_fire = cyc;
      end
      if (!busy) begin
         if (cfg_wr_en) begin
            if (cfg_stage < ST) m_shadow[cfg_stage] = cfg_data;
            else m_err = 1;
         end
         if (cfg_commit) begin
            m_pend = 1;
            m_swap = (cyc + 2 > m_last_fire + LAT + 2) ? cyc + 2 : m_last_fire + LAT + 2;
         end
      end else begin
         if (cfg_wr_en) m_err = 1;
         if (cyc == m_swap) begin
            m_active = m_shadow;
            m_loaded = 1;
            m_pend = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit wr, input int stage, input logic [15:0] data, input bit commit, input bit valid);
      cfg_wr_en  = wr;
      cfg_stage  = 4'(stage);
      cfg_data   = data;
      cfg_commit = commit;
      in_valid   = valid;
      step();
   endtask

   // Assert reset between clock edges and confirm outputs clear without waiting for an edge
   task automatic do_reset();
      cfg_wr_en = 0; cfg_commit = 0; in_valid = 0; cfg_stage = '0; cfg_data = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst cfg_busy", cfg_busy, 0);
      check("rst in_ready", in_ready, 0);
      check("rst cfg_loaded", cfg_loaded, 0);
      check("rst cfg_err", cfg_err, 0);
      for (int k = 0; k < ST; k++) check($sformatf("rst switch_set[%0d]", k), switch_set[k], 0);
`ifdef BENES_SEQ_PERM_CNT_EN
      check("rst perm_cnt", perm_cnt, 0);
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         int st;
         st = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
         drive($urandom_range(0, 3) == 0, st, 16'($urandom), $urandom_range(0, 24) == 0,
               $urandom_range(0, 9) < 7);
      end
   endtask

   initial begin
      model_reset();
      do_reset();
      for (int i = 0; i < 20; i++) drive(0, 0, 16'h0, 0, 1);
      for (int k = 0; k < ST; k++) drive(1, k, 16'hFFFF, 0, 0);
      drive(0, 0, 16'h0, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 16'h0, 0, 1);
      for (int i = 0; i < 12; i++) drive(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 16'h0, 0, 1);
      drive(1, 3, 16'h1234, 1, 1);
      drive(1, 5, 16'hBEEF, 0, 1);
      for (int i = 0; i < 12; i++) drive(0, 0, 16'h0, 0, 0);
      drive(1, 9, 16'hAAAA, 0, 0);
      drive(0, 0, 16'h0, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 0, 0);
      random_phase(1500);
      for (int i = 0; i < 20 && m_pend; i++) drive(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 0, 1);
      drive(1, 2, 16'h00F0, 1, 1);
      drive(0, 0, 16'h0, 0, 0);
      drive(0, 0, 16'h0, 0, 0);
      do_reset();
      for (int k = 0; k < ST; k++) drive(1, k, 16'($urandom), 0, 0);
      drive(0, 0, 16'h0, 1, 0);
      random_phase(600);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
